io_input_port: RTL

- Producer side of the PC/memory unit's memory-mapped input channel.
- Buffers 16-bit words from an external input device (switch bank / keypad latch) in a small FIFO.
- Presents the head word on `Input` with a valid flag; pops the head when the memory unit signals consumption on `InputRecv`.
- Supports the memory unit's `InputRst` flush and reports overflow.

---
 rtl/io_input_port.sv | 105 ++++++++++
 1 files changed

// File: rtl/io_input_port.sv
// ---------------------------------------------------------------------------
// io_input_port
//   Producer side of the memory unit's memory-mapped input channel. Words
//   from an external device (switch bank / keypad latch) are captured on each
//   rising edge of the asynchronous dev_strobe. They are then queued in a
//   small FIFO and presented head-first to the memory unit.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   dev_data    device word, held stable from strobe rise until the push edge
//   dev_strobe  device write strobe (async level); one push per rising edge
//   Input       head-of-FIFO word, 16'h0000 when empty
//   InputValid  FIFO non-empty
//   InputRecv   one-cycle pulse: head consumed (pop)
//   InputRst    synchronous flush, highest priority
//   dev_full    FIFO holds DEPTH words
//   overflow    sticky flag: a push was dropped because the FIFO was full
//   count       occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module io_input_port #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   dev_data,
    input  logic          dev_strobe,
    output logic [15:0]   Input,
    output logic          InputValid,
    input  logic          InputRecv,
    input  logic          InputRst,
    output logic          dev_full,
    output logic          overflow,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic                   r_s1, r_s2, r_s3;
    logic [AW-1:0]          r_wptr, r_rptr;
    logic [AW:0]            r_count;
    logic                   r_overflow;
    logic [DEPTH-1:0][15:0] r_mem;

    logic w_push_req, w_full, w_empty, w_pop, w_push, w_drop;

    // s1/s2 resynchronise the strobe and s3 delays s2 for edge detection.
    // InputRst deliberately leaves these alone. A strobe that is still high
    // across a flush therefore does not produce a second push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= dev_strobe;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_push_req = r_s2 & ~r_s3;
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_pop      = InputRecv & ~w_empty;
    // When full, a push is still accepted if the head is popped on the same edge.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (InputRst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_drop) r_overflow <= 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset; empty slots are masked at the output.
    always_ff @(posedge clk) begin
        if (w_push && !InputRst) r_mem[r_wptr] <= dev_data;
    end

    assign Input      = w_empty ? 16'h0000 : r_mem[r_rptr];
    assign InputValid = ~w_empty;
    assign dev_full   = w_full;
    assign overflow   = r_overflow;
    assign count      = r_count;

endmodule
